// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, constants and helpers for the clk_div_gen clock generator.
// Contents: DIV_W_DEF (default and maximum divide field width), MIN_DIV (smallest legal
// period), ch_cfg_t (per-channel configuration payload) and clamp_div().
// Optional feature macro: CLK_DIV_PHASE_EN adds a phase field to ch_cfg_t.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 16;
   localparam int unsigned MIN_DIV   = 2;

   // Channel configuration, held both as a shadow copy and as the live copy.
   typedef struct packed {
      logic [DIV_W_DEF-1:0] div;
      logic [DIV_W_DEF-1:0] high;
      logic                 en;
`ifdef CLK_DIV_PHASE_EN
      logic [DIV_W_DEF-1:0] phase;
`endif
   } ch_cfg_t;

   // Periods shorter than MIN_DIV cannot form a square wave, so they are raised to it.
   function automatic logic [DIV_W_DEF-1:0] clamp_div(input logic [DIV_W_DEF-1:0] div);
      return (div < DIV_W_DEF'(MIN_DIV)) ? DIV_W_DEF'(MIN_DIV) : div;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divided-clock channel with double-buffered configuration.
// Ports: clk, rst (sync, active-high), lock_s (synchronised PLL lock), wr (accepted
// write for this channel), cfg (write payload), pending (shadow not yet applied),
// clk_out / tick / active (registered channel outputs).
// Optional feature macro: CLK_DIV_PHASE_EN (counter start value = phase mod div).
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned RST_DIV  = 2,
   parameter int unsigned RST_HIGH = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    lock_s,
   input  logic    wr,
   input  ch_cfg_t cfg,
   output logic    pending,
   output logic    clk_out,
   output logic    tick,
   output logic    active
);

   ch_cfg_t              shadow;
   ch_cfg_t              act;
   ch_cfg_t              act_nxt;
   logic [DIV_W_DEF-1:0] cnt;
   logic [DIV_W_DEF-1:0] cnt_nxt;
   logic [DIV_W_DEF-1:0] start_nxt;
   logic [DIV_W_DEF-1:0] div_eff;
   logic                 running;
   logic                 at_end;
   logic                 apply;

   // Apply scheduling and counter next-state.
   always_comb begin
      div_eff = clamp_div(act.div);
      running = lock_s && act.en;
      at_end  = (cnt >= div_eff - DIV_W_DEF'(1));
      // A running channel only switches at its period boundary; an idle one at once.
      apply   = pending && (!running || at_end);
      act_nxt = apply ? shadow : act;
`ifdef CLK_DIV_PHASE_EN
      start_nxt = act_nxt.phase % clamp_div(act_nxt.div);
`else
      start_nxt = '0;
`endif
      // Idle counters sit at their start value so a lock edge aligns all channels.
      if (!lock_s || !act_nxt.en || apply) begin
         cnt_nxt = start_nxt;
      end else if (at_end) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + DIV_W_DEF'(1);
      end
   end

   // Configuration, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= '0;
         shadow.div  <= DIV_W_DEF'(RST_DIV);
         shadow.high <= DIV_W_DEF'(RST_HIGH);
         act         <= '0;
         act.div     <= DIV_W_DEF'(RST_DIV);
         act.high    <= DIV_W_DEF'(RST_HIGH);
         pending     <= 1'b0;
         cnt         <= '0;
         clk_out     <= 1'b0;
         tick        <= 1'b0;
         active      <= 1'b0;
      end else begin
         act <= act_nxt;
         cnt <= cnt_nxt;
         // wr never coincides with apply: the write port stalls while pending.
         if (wr) begin
            shadow  <= cfg;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
         clk_out <= running && (cnt < act.high);
         tick    <= running && (cnt == '0);
         active  <= lock_s && act_nxt.en;
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: CH_NUM programmable divided clocks derived from the PLL output clock.
// Ports: clk, rst (sync, active-high), locked_i (async PLL lock), cfg_valid/cfg_ready
// write handshake, cfg_ch/cfg_div/cfg_high/cfg_en write payload, clk_out/tick/active
// per-channel outputs. DIV_W may not exceed clk_div_pkg::DIV_W_DEF.
// Optional feature macro: CLK_DIV_PHASE_EN adds the cfg_phase input.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter  int unsigned CH_NUM   = 4,
   parameter  int unsigned DIV_W    = DIV_W_DEF,
   parameter  int unsigned RST_DIV  = 2,
   parameter  int unsigned RST_HIGH = 1,
   localparam int unsigned CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              locked_i,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_high,
   input  logic              cfg_en,
`ifdef CLK_DIV_PHASE_EN
   input  logic [DIV_W-1:0]  cfg_phase,
`endif
   output logic [CH_NUM-1:0] clk_out,
   output logic [CH_NUM-1:0] tick,
   output logic [CH_NUM-1:0] active
);

   logic              lock_meta;
   logic              lock_s;
   logic [CH_NUM-1:0] pending;
   logic [CH_NUM-1:0] wr;
   ch_cfg_t           cfg_w;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= locked_i;
         lock_s    <= lock_meta;
      end
   end

   // Ready reflects the addressed channel; an out-of-range channel accepts and drops.
   always_comb begin
      cfg_ready = 1'b1;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
      end
   end

   // Write payload shared by all channels.
   always_comb begin
      cfg_w      = '0;
      cfg_w.div  = DIV_W_DEF'(cfg_div);
      cfg_w.high = DIV_W_DEF'(cfg_high);
      cfg_w.en   = cfg_en;
`ifdef CLK_DIV_PHASE_EN
      cfg_w.phase = DIV_W_DEF'(cfg_phase);
`endif
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

      clk_div_ch #(
         .RST_DIV  (RST_DIV),
         .RST_HIGH (RST_HIGH)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .lock_s  (lock_s),
         .wr      (wr[i]),
         .cfg     (cfg_w),
         .pending (pending[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .active  (active[i])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen (CH_NUM = 4).
// Inputs are driven and outputs sampled on the falling edge of clk.
// Optional feature macro: CLK_DIV_PHASE_EN enables the phase-offset scenario.
module tb_clk_div_gen;

   localparam int unsigned CH_NUM = 4;
   localparam int unsigned DIV_W  = 16;

   logic              clk;
   logic              rst;
   logic              locked_i;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_high;
   logic              cfg_en;
`ifdef CLK_DIV_PHASE_EN
   logic [DIV_W-1:0]  cfg_phase;
`endif
   logic [CH_NUM-1:0] clk_out;
   logic [CH_NUM-1:0] tick;
   logic [CH_NUM-1:0] active;

   int n_checks = 0;
   int n_fail   = 0;

   clk_div_gen #(
      .CH_NUM   (CH_NUM),
      .DIV_W    (DIV_W),
      .RST_DIV  (2),
      .RST_HIGH (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .locked_i  (locked_i),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_en    (cfg_en),
`ifdef CLK_DIV_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .clk_out   (clk_out),
      .tick      (tick),
      .active    (active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // One-cycle write; cfg_ch is left on the written channel afterwards.
   task automatic cfg_write(input logic [1:0] ch, input int unsigned div,
                            input int unsigned high, input logic en);
      cfg_ch    = ch;
      cfg_div   = DIV_W'(div);
      cfg_high  = DIV_W'(high);
      cfg_en    = en;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_v;
      rst       = 1'b1;
      locked_i  = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_high  = '0;
      cfg_en    = 1'b0;
`ifdef CLK_DIV_PHASE_EN
      cfg_phase = '0;
`endif
      steps(3);
      check("rst_clk_out", 32'(clk_out), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      check("rst_active", 32'(active), 32'h0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
      rst = 1'b0;

      // 1: ch0 div=4 high=2 written while unlocked, then lock.
      cfg_write(2'd0, 4, 2, 1'b1);
      check("t1_ready_pending", 32'(cfg_ready), 32'h0);
      step();
      check("t1_ready_applied", 32'(cfg_ready), 32'h1);
      check("t1_active_unlocked", 32'(active), 32'h0);
      locked_i = 1'b1;
      steps(2);
      check("t1_active_presync", 32'(active), 32'h0);
      check("t1_clk_presync", 32'(clk_out), 32'h0);
      for (int j = 0; j < 8; j++) begin
         step();
         check($sformatf("t1_clk_%0d", j), 32'(clk_out), 32'((j % 4) < 2 ? 1 : 0));
         check($sformatf("t1_tick_%0d", j), 32'(tick), 32'((j % 4) == 0 ? 1 : 0));
         check($sformatf("t1_active_%0d", j), 32'(active), 32'h1);
      end

      // 2: reprogram ch0 to div=6 high=3 mid-run; old period completes first.
      cfg_write(2'd0, 6, 3, 1'b1);
      check("t2_ready_0", 32'(cfg_ready), 32'h0);
      check("t2_clk_0", 32'(clk_out[0]), 32'h1);
      for (int k = 1; k < 4; k++) begin
         step();
         check($sformatf("t2_ready_%0d", k), 32'(cfg_ready), 32'(k == 3 ? 1 : 0));
         check($sformatf("t2_clk_%0d", k), 32'(clk_out[0]), 32'(k == 1 ? 1 : 0));
      end
      for (int j = 0; j < 12; j++) begin
         step();
         check($sformatf("t2_newclk_%0d", j), 32'(clk_out[0]), 32'((j % 6) < 3 ? 1 : 0));
         check($sformatf("t2_newtick_%0d", j), 32'(tick[0]), 32'((j % 6) == 0 ? 1 : 0));
      end

      // 3: ch1 div=1 (clamped to 2) high=0; ch2 div=5 high=9 (constant high).
      cfg_write(2'd1, 1, 0, 1'b1);
      check("t3_ready_ch1", 32'(cfg_ready), 32'h0);
      cfg_write(2'd2, 5, 9, 1'b1);
      for (int j = 0; j < 10; j++) begin
         step();
         check($sformatf("t3_ch1_clk_%0d", j), 32'(clk_out[1]), 32'h0);
         check($sformatf("t3_ch1_tick_%0d", j), 32'(tick[1]), 32'((j % 2) == 0 ? 1 : 0));
         check($sformatf("t3_ch2_clk_%0d", j), 32'(clk_out[2]), 32'(j >= 1 ? 1 : 0));
         check($sformatf("t3_ch2_tick_%0d", j), 32'(tick[2]),
               32'((j >= 1 && ((j - 1) % 5) == 0) ? 1 : 0));
         check($sformatf("t3_active_%0d", j), 32'(active[2:1]), 32'h3);
      end

      // 4: lock loss clears everything; four channels then start aligned.
      locked_i = 1'b0;
      steps(3);
      check("t4_unlock_clk", 32'(clk_out), 32'h0);
      check("t4_unlock_tick", 32'(tick), 32'h0);
      check("t4_unlock_active", 32'(active), 32'h0);
      for (int i = 0; i < 4; i++) cfg_write(2'(i), 3 + i, 1, 1'b1);
      steps(2);
      check("t4_idle_active", 32'(active), 32'h0);
      locked_i = 1'b1;
      steps(2);
      for (int j = 0; j < 12; j++) begin
         step();
         for (int i = 0; i < 4; i++) exp_v[i] = ((j % (3 + i)) == 0);
         check($sformatf("t4_tick_%0d", j), 32'(tick), 32'(exp_v));
         check($sformatf("t4_clk_%0d", j), 32'(clk_out), 32'(exp_v));
         check($sformatf("t4_active_%0d", j), 32'(active), 32'hf);
      end
      locked_i = 1'b0;
      steps(3);
      check("t4_drop_clk", 32'(clk_out), 32'h0);
      check("t4_drop_tick", 32'(tick), 32'h0);
      check("t4_drop_active", 32'(active), 32'h0);
      locked_i = 1'b1;
      steps(3);
      check("t4_relock_tick", 32'(tick), 32'hf);
      check("t4_relock_clk", 32'(clk_out), 32'hf);

      // 5: reset with a write still pending on ch3.
      cfg_write(2'd3, 10, 5, 1'b1);
      check("t5_ready_pending", 32'(cfg_ready), 32'h0);
      rst = 1'b1;
      step();
      check("t5_rst_clk", 32'(clk_out), 32'h0);
      check("t5_rst_tick", 32'(tick), 32'h0);
      check("t5_rst_active", 32'(active), 32'h0);
      check("t5_rst_ready", 32'(cfg_ready), 32'h1);
      rst = 1'b0;
      steps(4);
      check("t5_post_active", 32'(active), 32'h0);
      check("t5_post_clk", 32'(clk_out), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cfg_ch = 2'(i);
         #1;
         check($sformatf("t5_ready_ch%0d", i), 32'(cfg_ready), 32'h1);
      end
      locked_i = 1'b0;
      steps(3);

`ifdef CLK_DIV_PHASE_EN
      // 6: ch1 phase 2 leads ch0 phase 0 by two cycles.
      cfg_phase = DIV_W'(0);
      cfg_write(2'd0, 8, 4, 1'b1);
      cfg_phase = DIV_W'(2);
      cfg_write(2'd1, 8, 4, 1'b1);
      cfg_phase = DIV_W'(0);
      steps(2);
      locked_i = 1'b1;
      steps(2);
      for (int j = 0; j < 16; j++) begin
         step();
         exp_v = {2'b00, 1'(((j + 2) % 8) < 4), 1'((j % 8) < 4)};
         check($sformatf("t6_clk_%0d", j), 32'(clk_out), 32'(exp_v));
         exp_v = {2'b00, 1'(((j + 2) % 8) == 0), 1'((j % 8) == 0)};
         check($sformatf("t6_tick_%0d", j), 32'(tick), 32'(exp_v));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
